// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel edge detector. Two column-addressed line buffers feed a 3x3 window,
// and one saturated 12-bit magnitude per accepted pixel appears on all three colour channels.
module sobel_filter #(
  parameter int LINE_WIDTH = 640,
  parameter int DW         = 12
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic [DW-1:0] iDATA,
  input  logic          iDVAL,
  input  logic          iSOF,
  input  logic [1:0]    iMODE,
  output logic [DW-1:0] oRed,
  output logic [DW-1:0] oGreen,
  output logic [DW-1:0] oBlue,
  output logic          oDVAL
);

  localparam int CW = $clog2(LINE_WIDTH);
  localparam int GW = DW + 4;

  typedef logic [DW-1:0] pixelT;

  logic [CW-1:0] colCnt, pixCol, nextCol;
  logic [1:0]    rowCnt, pixRow, nextRow;

  pixelT lineBuf0 [LINE_WIDTH];
  pixelT lineBuf1 [LINE_WIDTH];

  // Capture stage: line-buffer reads and the accepted pixel with its tags.
  logic       capValid, capBorder;
  logic [1:0] capMode;
  pixelT      capPix, capLb0, capLb1;

  logic       s1Valid, s1Border;
  logic [1:0] s1Mode;
  pixelT      s1Pix;
  pixelT      win [3][3];

  logic                 s2Valid, s2Border;
  logic [1:0]           s2Mode;
  pixelT                s2Pix;
  logic signed [GW-1:0] s2Gx, s2Gy, gxComb, gyComb;

  logic [GW-2:0] absX, absY;
  logic [GW-1:0] sumMag;
  pixelT         resultNext, resultQ;

  function automatic logic signed [GW-1:0] weightedSum(input pixelT a, input pixelT m, input pixelT b);
    logic [GW-1:0] s;
    s = GW'(a) + (GW'(m) << 1) + GW'(b);
    return $signed(s);
  endfunction

  function automatic logic [GW-2:0] absVal(input logic signed [GW-1:0] v);
    logic [GW-1:0] mag;
    mag = v[GW-1] ? $unsigned(-v) : $unsigned(v);
    return mag[GW-2:0];
  endfunction

  // iSOF forces this pixel to (0,0), which also overrides a simultaneous column wrap.
  always_comb begin
    pixCol = iSOF ? '0 : colCnt;
    pixRow = iSOF ? '0 : rowCnt;
    if (pixCol == CW'(LINE_WIDTH - 1)) begin
      nextCol = '0;
      nextRow = (pixRow == 2'd2) ? 2'd2 : pixRow + 2'd1;
    end else begin
      nextCol = pixCol + CW'(1);
      nextRow = pixRow;
    end
  end

  // NOTE: line buffers are plain storage with no reset; stale contents are masked by the row<2 border rule.
  always_ff @(posedge iCLK) begin
    if (iDVAL && !iRST) begin
      lineBuf0[pixCol] <= iDATA;
      lineBuf1[pixCol] <= lineBuf0[pixCol];
    end
  end

  always_comb begin
    gxComb = weightedSum(win[0][2], win[1][2], win[2][2]) - weightedSum(win[0][0], win[1][0], win[2][0]);
    gyComb = weightedSum(win[2][0], win[2][1], win[2][2]) - weightedSum(win[0][0], win[0][1], win[0][2]);
  end

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    absX   = absVal(s2Gx);
    absY   = absVal(s2Gy);
    sumMag = '0;
    case (s2Mode)
      2'd0:    sumMag = {1'b0, absX} + {1'b0, absY};
      2'd1:    sumMag = {1'b0, absX};
      2'd2:    sumMag = {1'b0, absY};
      default: sumMag = '0;
    endcase
    if (s2Mode == 2'd3)       resultNext = s2Pix;
    else if (s2Border)        resultNext = '0;
    else if (|sumMag[GW-1:DW]) resultNext = '1;
    else                      resultNext = sumMag[DW-1:0];
  end

  // NOTE: all pipeline state uses non-blocking assignments so every stage sees last cycle's values.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      colCnt    <= '0;
      rowCnt    <= '0;
      capValid  <= 1'b0;
      capBorder <= 1'b0;
      capMode   <= '0;
      capPix    <= '0;
      capLb0    <= '0;
      capLb1    <= '0;
      s1Valid   <= 1'b0;
      s1Border  <= 1'b0;
      s1Mode    <= '0;
      s1Pix     <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
      s2Valid   <= 1'b0;
      s2Border  <= 1'b0;
      s2Mode    <= '0;
      s2Pix     <= '0;
      s2Gx      <= '0;
      s2Gy      <= '0;
      resultQ   <= '0;
      oDVAL     <= 1'b0;
    end else begin
      capValid <= iDVAL;
      if (iDVAL) begin
        colCnt    <= nextCol;
        rowCnt    <= nextRow;
        capPix    <= iDATA;
        capLb0    <= lineBuf0[pixCol];
        capLb1    <= lineBuf1[pixCol];
        capBorder <= (pixRow < 2'd2) || (pixCol < CW'(2));
        capMode   <= iMODE;
      end

      s1Valid <= capValid;
      if (capValid) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= capLb1;
        win[1][2] <= capLb0;
        win[2][2] <= capPix;
        s1Border  <= capBorder;
        s1Mode    <= capMode;
        s1Pix     <= capPix;
      end

      s2Valid <= s1Valid;
      if (s1Valid) begin
        s2Gx     <= gxComb;
        s2Gy     <= gyComb;
        s2Border <= s1Border;
        s2Mode   <= s1Mode;
        s2Pix    <= s1Pix;
      end

      oDVAL <= s2Valid;
      if (s2Valid) resultQ <= resultNext;
    end
  end

  assign oRed   = resultQ;
  assign oGreen = resultQ;
  assign oBlue  = resultQ;

endmodule

// File: tb/tb_sobel_filter.sv
// Bench for sobel_filter: a frame-level Sobel model predicts every result and its arrival edge;
// a negedge monitor compares each output cycle against it.
module tb_sobel_filter;

  localparam int LW = 640;
  localparam int DW = 12;

  logic          iCLK = 1'b0;
  logic          iRST, iDVAL, iSOF;
  logic [DW-1:0] iDATA;
  logic [1:0]    iMODE;
  logic [DW-1:0] oRed, oGreen, oBlue;
  logic          oDVAL;

  sobel_filter #(.LINE_WIDTH(LW), .DW(DW)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iDVAL(iDVAL), .iSOF(iSOF), .iMODE(iMODE),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oDVAL(oDVAL)
  );

  always #5 iCLK = ~iCLK;

  int edgeCnt = 0;
  always @(posedge iCLK) edgeCnt++;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, want);
    end
  endtask

  typedef int winT [3][3];
  typedef struct { int val; int acceptEdge; int row; int col; } expT;

  expT expQ[$];
  int  frameBuf [4][LW];
  int  obsImg [8][LW];
  int  mRow, mCol;
  int  accepts = 0;
  int  dvalCount = 0;
  int  lastOut = 0;
  bit  recording = 0;
  int  seqLog[$];
  int  seqA[$];

  function automatic int sobelMag(input winT w, input int mode);
    int gx, gy, ax, ay, s;
    gx = (w[0][2] + 2*w[1][2] + w[2][2]) - (w[0][0] + 2*w[1][0] + w[2][0]);
    gy = (w[2][0] + 2*w[2][1] + w[2][2]) - (w[0][0] + 2*w[0][1] + w[0][2]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    case (mode)
      0:       s = ax + ay;
      1:       s = ax;
      default: s = ay;
    endcase
    return (s > 4095) ? 4095 : s;
  endfunction

  function automatic void modelReset();
    mRow = 0;
    mCol = 0;
    expQ.delete();
  endfunction

  // The image is kept by true row index (mod 4); a window is just the 3x3 neighbourhood in it.
  function automatic void modelAccept(input int data, input bit sof, input int mode, input int edgeIdx);
    expT  e;
    winT  w;
    if (sof) begin
      mRow = 0;
      mCol = 0;
    end
    frameBuf[mRow % 4][mCol] = data;
    if (mode == 3) e.val = data;
    else if (mRow < 2 || mCol < 2) e.val = 0;
    else begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[r][c] = frameBuf[(mRow - 2 + r) % 4][mCol - 2 + c];
      e.val = sobelMag(w, mode);
    end
    e.acceptEdge = edgeIdx;
    e.row = mRow;
    e.col = mCol;
    expQ.push_back(e);
    mCol++;
    if (mCol == LW) begin
      mCol = 0;
      mRow++;
    end
  endfunction

  task automatic driveCycle(input logic rst, input logic dval, input logic [DW-1:0] data,
                            input logic sof, input logic [1:0] mode);
    @(negedge iCLK);
    #1;
    iRST  = rst;
    iDVAL = dval;
    iDATA = data;
    iSOF  = sof;
    iMODE = mode;
    if (rst) modelReset();
    else if (dval) begin
      modelAccept(int'(data), sof, int'(mode), edgeCnt + 1);
      accepts++;
    end
  endtask

  task automatic sendPix(input logic [DW-1:0] data, input logic sof, input logic [1:0] mode, input int gapPct);
    while ($urandom_range(99) < gapPct)
      driveCycle(1'b0, 1'b0, 12'($urandom), 1'($urandom), 2'($urandom));
    driveCycle(1'b0, 1'b1, data, sof, mode);
  endtask

  function automatic logic [DW-1:0] pixelOf(input int kind, input int r, input int c);
    case (kind)
      0:       return 12'd1000;
      1:       return (c < 320) ? 12'd0 : 12'd1000;
      2:       return (c < 320) ? 12'd0 : 12'd4095;
      3:       return (r < 3) ? 12'd0 : 12'd1000;
      default: return 12'($urandom_range(4095));
    endcase
  endfunction

  task automatic sendFrame(input int kind, input int rows, input int mode, input int gapPct);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < LW; c++)
        sendPix(pixelOf(kind, r, c), (r == 0 && c == 0),
                (mode < 0) ? 2'($urandom_range(3)) : 2'(mode), gapPct);
  endtask

  task automatic drain();
    int n = 0;
    while (expQ.size() > 0 && n < 20) begin
      driveCycle(1'b0, 1'b0, 12'd0, 1'b0, 2'd0);
      n++;
    end
    check("drain timeout", 32'(expQ.size()), 0);
  endtask

  function automatic void clearObs();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < LW; c++)
        obsImg[r][c] = -1;
  endfunction

  // Monitor: outputs are stable at the falling edge, half a cycle after the posedge that set them.
  initial begin
    expT e;
    forever begin
      @(negedge iCLK);
      if (edgeCnt > 0) begin
        if (iRST) begin
          check("reset oDVAL", 32'(oDVAL), 0);
          check("reset outputs", 32'(oRed | oGreen | oBlue), 0);
          lastOut = 0;
        end else begin
          check("channels equal", 32'(oRed == oGreen && oGreen == oBlue), 1);
          if (oDVAL === 1'b1) begin
            if (expQ.size() == 0) check("spurious oDVAL", 32'(oDVAL), 0);
            else begin
              e = expQ.pop_front();
              check($sformatf("latency r%0d c%0d", e.row, e.col), edgeCnt, e.acceptEdge + 3);
              check($sformatf("pixel r%0d c%0d", e.row, e.col), 32'(oRed), e.val);
              if (e.row < 8) obsImg[e.row][e.col] = int'(oRed);
              if (recording) seqLog.push_back(int'(oRed));
              dvalCount++;
              lastOut = int'(oRed);
            end
          end else begin
            check("oDVAL low", 32'(oDVAL), 0);
            check("hold value", 32'(oRed), lastOut);
            if (expQ.size() > 0 && expQ[0].acceptEdge + 3 <= edgeCnt) begin
              check($sformatf("missing output r%0d c%0d", expQ[0].row, expQ[0].col), 32'(oDVAL), 1);
              void'(expQ.pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    winT w;
    int  d0, a0, diffs;

    iRST = 1'b1; iDVAL = 1'b1; iDATA = 12'd777; iSOF = 1'b0; iMODE = 2'd0;
    modelReset();
    clearObs();

    // Hand-computed windows that pin the model arithmetic.
    for (int r = 0; r < 3; r++) begin w[r][0] = 0; w[r][1] = 0; w[r][2] = 1000; end
    check("model step mode0", sobelMag(w, 0), 4000);
    check("model step mode2", sobelMag(w, 2), 0);
    for (int r = 0; r < 3; r++) w[r][2] = 4095;
    check("model saturate", sobelMag(w, 0), 4095);
    for (int c = 0; c < 3; c++) begin w[0][c] = 1000; w[1][c] = 500; w[2][c] = 0; end
    check("model neg gy", sobelMag(w, 2), 4000);

    // Reset held four edges with iDVAL high; the monitor checks outputs each cycle.
    repeat (3) driveCycle(1'b1, 1'b1, 12'($urandom), 1'b0, 2'd0);

    d0 = dvalCount;
    sendFrame(0, 8, 0, 0);
    drain();
    check("flat pulse count", dvalCount - d0, 5120);

    clearObs();
    sendFrame(1, 5, 0, 0);
    drain();
    check("step 3,320", obsImg[3][320], 4000);
    check("step 3,321", obsImg[3][321], 4000);
    check("step 3,319", obsImg[3][319], 0);
    check("step 3,322", obsImg[3][322], 0);
    check("step row1 border", obsImg[1][320], 0);

    sendFrame(1, 5, 2, 0);
    drain();
    check("step mode2", obsImg[3][320], 0);

    sendFrame(2, 5, 0, 0);
    drain();
    check("sat mode0", obsImg[3][320], 4095);
    sendFrame(2, 5, 1, 0);
    drain();
    check("sat mode1", obsImg[4][321], 4095);
    sendFrame(2, 5, 3, 0);
    drain();
    check("pass row0", obsImg[0][320], 4095);
    check("pass col0", obsImg[4][0], 0);

    // Same image gapless then with ~30% idle cycles: identical output sequences.
    recording = 1;
    seqLog.delete();
    sendFrame(2, 5, 0, 0);
    drain();
    seqA = seqLog;
    seqLog.delete();
    a0 = accepts;
    d0 = dvalCount;
    sendFrame(2, 5, 0, 30);
    drain();
    recording = 0;
    check("gap dval count", dvalCount - d0, accepts - a0);
    check("gap seq length", 32'(seqLog.size()), 32'(seqA.size()));
    diffs = 0;
    for (int i = 0; i < seqA.size() && i < seqLog.size(); i++)
      if (seqA[i] != seqLog[i]) diffs++;
    check("gap seq diffs", diffs, 0);

    // Mid-line iSOF at (5,100) of a flat frame, then a horizontal step at new row 3.
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < ((r == 5) ? 100 : LW); c++)
        sendPix(12'd1000, (r == 0 && c == 0), 2'd0, 0);
    clearObs();
    sendFrame(3, 6, 0, 0);
    drain();
    check("sof 3,50", obsImg[3][50], 4000);
    check("sof 4,50", obsImg[4][50], 4000);
    check("sof 3,2", obsImg[3][2], 4000);
    check("sof 3,1 border", obsImg[3][1], 0);
    check("sof 5,50", obsImg[5][50], 0);
    check("sof 2,50", obsImg[2][50], 0);
    check("sof 1,300", obsImg[1][300], 0);
    check("sof 0,200", obsImg[0][200], 0);

    // Random pixels, per-pixel modes, gaps, stray iSOF, and a mid-line reset.
    sendFrame(4, 3, -1, 30);
    for (int i = 0; i < 300; i++)
      sendPix(12'($urandom), ($urandom_range(199) == 0), 2'($urandom), 30);
    repeat (2) driveCycle(1'b1, 1'b1, 12'($urandom), 1'b0, 2'd0);
    clearObs();
    for (int i = 0; i < 1400; i++)
      sendPix(12'($urandom), 1'b0, 2'($urandom), 30);
    drain();
    check("post-reset origin", obsImg[0][0] >= 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
